// File: rtl/lane_wb_buffer_pkg.sv
// Shared types and sizing for the lane write-back path.
package lane_wb_buffer_pkg;

   localparam int VECTOR_REG_WIDTH      = 32;
   localparam int NUM_OF_VECTOR_REG     = 32;
   localparam int ELEMS_PER_REG_DEFAULT = 64;
   localparam int REG_IDX_W             = $clog2(NUM_OF_VECTOR_REG);

   // One queued lane result: destination register plus its data.
   typedef struct packed {
      logic [REG_IDX_W-1:0]        vreg;
      logic [VECTOR_REG_WIDTH-1:0] data;
   } wb_entry_t;

endpackage

// File: rtl/lane_wb_buffer_fifo.sv
// Synchronous FIFO with occupancy count; full/empty come from the count so
// wrapped pointers never need an extra lap bit.
// The caller qualifies push/pop: pop only when non-empty, push only when
// not full or popping in the same cycle.
module sync_fifo #(
   parameter  int DEPTH = 8,
   parameter  int WIDTH = 8,
   localparam int PTR_W = $clog2(DEPTH),
   localparam int CNT_W = PTR_W + 1
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic [CNT_W-1:0] count,
   output logic             full,
   output logic             empty
);

   logic [WIDTH-1:0] mem [DEPTH];
   logic [PTR_W-1:0] wr_ptr;
   logic [PTR_W-1:0] rd_ptr;

   // Entry storage.
   // NOTE: storage is deliberately not reset; count gates every read, so
   // stale contents are never observed and the array maps onto plain RAM.
   always_ff @(posedge clk) begin
      if (push) mem[wr_ptr] <= wdata;
   end

   // Pointers and occupancy; flush restarts them like reset does.
   // NOTE: all sequential state uses non-blocking assignments so every
   // register samples pre-edge values regardless of statement order.
   always_ff @(posedge clk) begin
      if (reset || flush) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + PTR_W'(1);
         if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
         case ({push, pop})
            2'b10:   count <= count + CNT_W'(1);
            2'b01:   count <= count - CNT_W'(1);
            default: count <= count;
         endcase
      end
   end

   assign rdata = mem[rd_ptr];
   assign full  = (count == CNT_W'(DEPTH));
   assign empty = (count == '0);

endmodule

// File: rtl/lane_wb_buffer.sv
// Receive-side write-back buffer: queues lane results, drains them into the
// vector register file with element numbering, and pulses per-register
// completion.
module lane_wb_buffer
   import lane_wb_buffer_pkg::*;
#(
   parameter  int DEPTH         = 8,
   parameter  int SLACK         = 2,
   parameter  int ELEMS_PER_REG = ELEMS_PER_REG_DEFAULT,
   localparam int CNT_W         = $clog2(DEPTH) + 1,
   localparam int ELEM_W        = $clog2(ELEMS_PER_REG)
) (
   input  logic                        clk,
   input  logic                        reset,
   input  logic                        result_vld,
   input  logic [REG_IDX_W-1:0]        vec_reg_in,
   input  logic [VECTOR_REG_WIDTH-1:0] data_in,
   output logic                        wb_full_lane,
   input  logic                        flush,
   output logic                        rf_we,
   output logic [REG_IDX_W-1:0]        rf_reg,
   output logic [ELEM_W-1:0]           rf_elem,
   output logic [VECTOR_REG_WIDTH-1:0] rf_data,
   input  logic                        rf_ready,
   output logic                        reg_done,
   output logic [REG_IDX_W-1:0]        done_reg,
   output logic                        overflow,
   output logic                        seq_err
);

   localparam logic [ELEM_W-1:0] LAST_ELEM = ELEM_W'(ELEMS_PER_REG - 1);

   wb_entry_t            wr_entry;
   wb_entry_t            head;
   logic [CNT_W-1:0]     count;
   logic                 full;
   logic                 empty;
   logic                 push;
   logic                 pop;
   logic                 accept;
   logic [ELEM_W-1:0]    elem_cnt;
   logic [REG_IDX_W-1:0] cur_reg;
   logic                 seq_break;
   logic [ELEM_W-1:0]    elem_eff;
   logic [ELEM_W-1:0]    elem_next;

   assign wr_entry = '{vreg: vec_reg_in, data: data_in};
   assign pop      = rf_we && rf_ready;
   assign push     = result_vld && !flush && (!full || pop);
   assign accept   = pop && !flush;

   sync_fifo #(
      .DEPTH (DEPTH),
      .WIDTH ($bits(wb_entry_t))
   ) u_fifo (
      .clk   (clk),
      .reset (reset),
      .flush (flush),
      .push  (push),
      .pop   (pop),
      .wdata (wr_entry),
      .rdata (head),
      .count (count),
      .full  (full),
      .empty (empty)
   );

   // Element index for the head entry; a register change mid-way restarts at 0.
   // NOTE: every output gets a default first so no path can infer a latch.
   always_comb begin
      seq_break = 1'b0;
      elem_eff  = elem_cnt;
      elem_next = '0;
      if ((head.vreg != cur_reg) && (elem_cnt != '0)) begin
         seq_break = 1'b1;
         elem_eff  = '0;
      end
      if (elem_eff != LAST_ELEM) elem_next = elem_eff + ELEM_W'(1);
   end

   // Drain outputs are zero while empty so unwritten storage never leaks out.
   assign rf_we        = !empty;
   assign rf_reg       = empty ? '0 : head.vreg;
   assign rf_data      = empty ? '0 : head.data;
   assign rf_elem      = empty ? '0 : elem_eff;
   assign wb_full_lane = (count >= CNT_W'(DEPTH - SLACK));

   // Element counter, completion pulse and sticky error flags.
   always_ff @(posedge clk) begin
      if (reset) begin
         elem_cnt <= '0;
         cur_reg  <= '0;
         reg_done <= 1'b0;
         done_reg <= '0;
         overflow <= 1'b0;
         seq_err  <= 1'b0;
      end else begin
         reg_done <= 1'b0;
         if (flush) begin
            elem_cnt <= '0;
         end else if (accept) begin
            elem_cnt <= elem_next;
            cur_reg  <= head.vreg;
            if (seq_break) seq_err <= 1'b1;
            if (elem_eff == LAST_ELEM) begin
               reg_done <= 1'b1;
               done_reg <= head.vreg;
            end
         end
         if (result_vld && !flush && full && !pop) overflow <= 1'b1;
      end
   end

endmodule

// File: tb/tb_lane_wb_buffer.sv
// Scenario bench for lane_wb_buffer: a reference model predicts occupancy,
// element numbering and flags; expected writes queue at push, compare at handshake.
module tb_lane_wb_buffer;
   import lane_wb_buffer_pkg::*;

   localparam int DEPTH = 8;
   localparam int SLACK = 2;
   localparam int EPR   = ELEMS_PER_REG_DEFAULT;
   localparam int EW    = $clog2(EPR);

   logic                        clk = 1'b0;
   logic                        reset;
   logic                        result_vld;
   logic [REG_IDX_W-1:0]        vec_reg_in;
   logic [VECTOR_REG_WIDTH-1:0] data_in;
   logic                        wb_full_lane;
   logic                        flush;
   logic                        rf_we;
   logic [REG_IDX_W-1:0]        rf_reg;
   logic [EW-1:0]               rf_elem;
   logic [VECTOR_REG_WIDTH-1:0] rf_data;
   logic                        rf_ready;
   logic                        reg_done;
   logic [REG_IDX_W-1:0]        done_reg;
   logic                        overflow;
   logic                        seq_err;

   lane_wb_buffer #(.DEPTH(DEPTH), .SLACK(SLACK), .ELEMS_PER_REG(EPR)) dut (
      .clk(clk), .reset(reset), .result_vld(result_vld), .vec_reg_in(vec_reg_in),
      .data_in(data_in), .wb_full_lane(wb_full_lane), .flush(flush), .rf_we(rf_we),
      .rf_reg(rf_reg), .rf_elem(rf_elem), .rf_data(rf_data), .rf_ready(rf_ready),
      .reg_done(reg_done), .done_reg(done_reg), .overflow(overflow), .seq_err(seq_err)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [REG_IDX_W-1:0]        r;
      int                          e;
      logic [VECTOR_REG_WIDTH-1:0] d;
      bit                          s;
   } exp_t;

   exp_t                 sb[$];
   int                   total = 0;
   int                   bad   = 0;
   int                   mcount;
   bit                   m_ovf, m_seq, exp_done;
   logic [REG_IDX_W-1:0] exp_done_reg;
   logic [REG_IDX_W-1:0] p_cur;
   int                   p_cnt;

   task automatic model_clear();
      sb.delete();
      mcount = 0; m_ovf = 0; m_seq = 0; exp_done = 0;
      exp_done_reg = '0; p_cur = '0; p_cnt = 0;
   endtask

   // One clock: drive at negedge, compare, advance model, return 1ns after posedge.
   task automatic cycle(input bit vld, input int r, input int d, input bit rdy, input bit fl);
      exp_t e;
      bit   pop, acc;
      @(negedge clk);
      result_vld = vld; vec_reg_in = REG_IDX_W'(r); data_in = VECTOR_REG_WIDTH'(d);
      rf_ready = rdy; flush = fl;
      #1;
      total++;
      if (rf_we !== (mcount != 0)) begin
         bad++; $display("FAIL rf_we: got %b want %b (count %0d)", rf_we, mcount != 0, mcount);
      end
      total++;
      if (wb_full_lane !== (mcount >= DEPTH - SLACK)) begin
         bad++; $display("FAIL wb_full_lane: got %b want %b (count %0d)", wb_full_lane, mcount >= DEPTH - SLACK, mcount);
      end
      total++;
      if (reg_done !== exp_done || (exp_done && done_reg !== exp_done_reg)) begin
         bad++; $display("FAIL reg_done: got %b/%0d want %b/%0d", reg_done, done_reg, exp_done, exp_done_reg);
      end
      total++;
      if (overflow !== m_ovf || seq_err !== m_seq) begin
         bad++; $display("FAIL sticky_flags: got ovf=%b seq=%b want ovf=%b seq=%b", overflow, seq_err, m_ovf, m_seq);
      end
      pop = (mcount != 0) && rdy;
      exp_done = 0;
      if (pop) begin
         total++;
         if (sb.size() == 0) begin
            bad++; $display("FAIL rf_write: unexpected write reg=%0d elem=%0d data=%h", rf_reg, rf_elem, rf_data);
         end else begin
            e = sb.pop_front();
            if (rf_reg !== e.r || rf_elem !== EW'(e.e) || rf_data !== e.d) begin
               bad++; $display("FAIL rf_write: got reg=%0d elem=%0d data=%h want reg=%0d elem=%0d data=%h",
                               rf_reg, rf_elem, rf_data, e.r, e.e, e.d);
            end
            if (!fl) begin
               if (e.s) m_seq = 1;
               if (e.e == EPR - 1) begin exp_done = 1; exp_done_reg = e.r; end
            end
         end
      end
      acc = vld && !fl && (mcount < DEPTH || pop);
      if (vld && !fl && mcount == DEPTH && !pop) m_ovf = 1;
      if (fl) begin
         sb.delete(); mcount = 0; p_cnt = 0;
      end else begin
         mcount = mcount + int'(acc) - int'(pop);
         if (acc) begin
            e.r = REG_IDX_W'(r); e.d = VECTOR_REG_WIDTH'(d);
            e.s = (e.r != p_cur) && (p_cnt != 0);
            e.e = e.s ? 0 : p_cnt;
            p_cnt = (e.e == EPR - 1) ? 0 : e.e + 1;
            p_cur = e.r;
            sb.push_back(e);
         end
      end
      @(posedge clk);
      #1;
   endtask

   task automatic drain();
      int n = 0;
      while (mcount != 0 && n < 50) begin
         cycle(0, 0, 0, 1, 0); n++;
      end
      total++;
      if (mcount != 0 || sb.size() != 0) begin
         bad++; $display("FAIL drain_timeout: count %0d pending %0d want 0", mcount, sb.size());
      end
      cycle(0, 0, 0, 1, 0);
   endtask

   task automatic test_reset();
      @(negedge clk);
      reset = 1; result_vld = 0; flush = 0; rf_ready = 0; vec_reg_in = '0; data_in = '0;
      repeat (2) @(posedge clk);
      @(negedge clk); #1;
      total++;
      if ({rf_we, wb_full_lane, reg_done, overflow, seq_err} !== 5'b0 ||
          rf_reg !== '0 || rf_elem !== '0 || rf_data !== '0 || done_reg !== '0) begin
         bad++; $display("FAIL reset_outputs: we=%b full=%b done=%b ovf=%b seq=%b reg=%0d elem=%0d data=%h dreg=%0d want all 0",
                         rf_we, wb_full_lane, reg_done, overflow, seq_err, rf_reg, rf_elem, rf_data, done_reg);
      end
      reset = 0;
      model_clear();
   endtask

   task automatic test_single();
      cycle(1, 3, 'h55, 1, 0);
      total++;
      if (rf_we !== 1'b1 || rf_reg !== 3 || rf_elem !== 0 || rf_data !== 32'h55) begin
         bad++; $display("FAIL single_head: got we=%b reg=%0d elem=%0d data=%h want 1/3/0/55", rf_we, rf_reg, rf_elem, rf_data);
      end
      cycle(0, 0, 0, 1, 0);
      total++;
      if (rf_we !== 1'b0) begin
         bad++; $display("FAIL single_empty: got rf_we=%b want 0", rf_we);
      end
   endtask

   task automatic test_full_reg();
      int dones = 0;
      for (int i = 0; i < EPR; i++) cycle(1, 5, 'h500 + i, 1, 0);
      for (int i = 0; i < 3; i++) begin
         cycle(0, 0, 0, 1, 0);
         if (reg_done === 1'b1) dones++;
      end
      total++;
      if (dones != 1) begin
         bad++; $display("FAIL full_reg_done_count: got %0d pulses want 1", dones);
      end
   endtask

   task automatic test_full_push();
      for (int i = 0; i < DEPTH; i++) cycle(1, 4, 'h400 + i, 0, 0);
      cycle(1, 4, 'h4FF, 1, 0);
      total++;
      if (overflow !== 1'b0 || mcount != DEPTH || wb_full_lane !== 1'b1) begin
         bad++; $display("FAIL full_push_pop: got ovf=%b full=%b want ovf=0 full=1", overflow, wb_full_lane);
      end
      drain();
   endtask

   task automatic test_overflow();
      for (int i = 0; i < 6; i++) cycle(1, 4, 'h600 + i, 0, 0);
      total++;
      if (wb_full_lane !== 1'b1) begin
         bad++; $display("FAIL wb_full_after6: got %b want 1", wb_full_lane);
      end
      cycle(1, 4, 'h606, 0, 0);
      cycle(1, 4, 'h607, 0, 0);
      total++;
      if (overflow !== 1'b0) begin
         bad++; $display("FAIL no_overflow_at8: got %b want 0", overflow);
      end
      cycle(1, 4, 'hDEAD, 0, 0);
      total++;
      if (overflow !== 1'b1) begin
         bad++; $display("FAIL overflow_9th: got %b want 1", overflow);
      end
      drain();
   endtask

   task automatic test_seq_err();
      cycle(0, 0, 0, 0, 1);
      for (int i = 0; i < 10; i++) cycle(1, 2, 'h200 + i, 1, 0);
      cycle(1, 7, 'h777, 1, 0);
      drain();
      total++;
      if (seq_err !== 1'b1) begin
         bad++; $display("FAIL seq_err_set: got %b want 1", seq_err);
      end
   endtask

   task automatic test_flush();
      for (int i = 0; i < 4; i++) cycle(1, 6, 'h660 + i, 0, 0);
      cycle(1, 6, 'hBAD, 0, 1);
      total++;
      if (rf_we !== 1'b0 || wb_full_lane !== 1'b0) begin
         bad++; $display("FAIL flush_empty: got we=%b full=%b want 0/0", rf_we, wb_full_lane);
      end
      cycle(1, 1, 'h111, 1, 0);
      total++;
      if (rf_elem !== 0 || rf_reg !== 1) begin
         bad++; $display("FAIL flush_restart: got reg=%0d elem=%0d want 1/0", rf_reg, rf_elem);
      end
      drain();
   endtask

   initial begin
      test_reset();
      test_single();
      test_full_reg();
      test_full_push();
      test_overflow();
      test_seq_err();
      test_flush();
      for (int i = 0; i < 3; i++) cycle(1, 9, 'h900 + i, 0, 0);
      test_reset();
      cycle(0, 0, 0, 1, 0);
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
